fpro_bus_arbiter: RTL and testbench

Two-master arbiter for the FPro bus: it shares one FPro MMIO/video slave port between two requesters, such as the Avalon-side bridge and a local DMA or sequencer master. It registers the winning request, drives a single-cycle FPro strobe, captures read data, and returns a one-cycle acknowledge. Round-robin fairness applies, with an optional bus lock.

---
 rtl/fpro_bus_arbiter_if.sv | 48 ++++
 rtl/fpro_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_fpro_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpro_bus_arbiter_if.sv
// fpro_bus_arbiter_if: signal bundle between two requesters, the arbiter and one FPro slave port.
//   Requester side : m_req, m_wr, m_rd, m_video, m_lock, m0/m1_addr, m0/m1_wr_data -> arbiter
//                    m_ack, m_rd_data, grant_id, busy                               <- arbiter
//   FPro side      : fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data      <- arbiter
//                    fp_rd_data                                                      -> arbiter
//   modport slave  : the arbiter's view (it serves the requesters)
//   modport master : the requester/environment view
interface fpro_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        m_req;
  logic [1:0]        m_wr;
  logic [1:0]        m_rd;
  logic [1:0]        m_video;
  logic [1:0]        m_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wr_data;
  logic [DATA_W-1:0] m1_wr_data;
  logic [1:0]        m_ack;
  logic [DATA_W-1:0] m_rd_data;
  logic              grant_id;
  logic              busy;
  logic              fp_mmio_cs;
  logic              fp_video_cs;
  logic              fp_wr;
  logic              fp_rd;
  logic [ADDR_W-1:0] fp_addr;
  logic [DATA_W-1:0] fp_wr_data;
  logic [DATA_W-1:0] fp_rd_data;

  modport slave (
    input  m_req, m_wr, m_rd, m_video, m_lock,
    input  m0_addr, m1_addr, m0_wr_data, m1_wr_data,
    output m_ack, m_rd_data, grant_id, busy,
    output fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    input  fp_rd_data
  );

  modport master (
    output m_req, m_wr, m_rd, m_video, m_lock,
    output m0_addr, m1_addr, m0_wr_data, m1_wr_data,
    input  m_ack, m_rd_data, grant_id, busy,
    input  fp_mmio_cs, fp_video_cs, fp_wr, fp_rd, fp_addr, fp_wr_data,
    output fp_rd_data
  );
endinterface

// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: two-master round-robin arbiter sharing one FPro MMIO/video slave port.
//   IDLE latches the winning request, BUS drives a one-cycle registered strobe and captures
//   read data, ACK pulses m_ack[grant_id] and hands round-robin priority to the other master.
// Ports:
//   clk      - system clock
//   reset_n  - synchronous active-low reset
//   bus      - fpro_bus_arbiter_if.slave (requester handshake + FPro strobes/data)
// Optional feature: define FPRO_ARB_LOCK_EN to honour m_lock (bus lock by the last owner).
// Without it m_lock is ignored and arbitration is pure round-robin.
module fpro_bus_arbiter #(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fpro_bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t     state;
  logic       rr;
  logic [1:0] elig_c;
  logic       win_c;
  logic       win_wr_c;
  logic       win_rd_c;
  logic       win_video_c;

`ifdef FPRO_ARB_LOCK_EN
  logic lock_valid;
  logic lock_owner;
  logic op_lock;

  // While locked only the owner may be granted.
  always_comb begin
    elig_c = bus.m_req;
    if (lock_valid) begin
      elig_c = bus.m_req & (lock_owner ? 2'b10 : 2'b01);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.m_lock;
  assign elig_c      = bus.m_req;
`endif

  // Winner: rr breaks a tie, otherwise whichever single master is eligible.
  always_comb begin
    win_c       = (elig_c == 2'b11) ? rr : elig_c[1];
    win_wr_c    = bus.m_wr[win_c];
    win_rd_c    = bus.m_rd[win_c] & ~bus.m_wr[win_c];  // write wins when both are set
    win_video_c = bus.m_video[win_c];
  end

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      rr              <= 1'b0;
      bus.m_ack       <= 2'b00;
      bus.m_rd_data   <= '0;
      bus.grant_id    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.fp_mmio_cs  <= 1'b0;
      bus.fp_video_cs <= 1'b0;
      bus.fp_wr       <= 1'b0;
      bus.fp_rd       <= 1'b0;
      bus.fp_addr     <= '0;
      bus.fp_wr_data  <= '0;
`ifdef FPRO_ARB_LOCK_EN
      lock_valid      <= 1'b0;
      lock_owner      <= 1'b0;
      op_lock         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|elig_c) begin
            state           <= BUS;
            bus.busy        <= 1'b1;
            bus.grant_id    <= win_c;
            bus.fp_addr     <= ADDR_W'(win_c ? bus.m1_addr : bus.m0_addr);
            bus.fp_wr_data  <= DATA_W'(win_c ? bus.m1_wr_data : bus.m0_wr_data);
            // A no-op (neither wr nor rd) selects no target at all.
            bus.fp_mmio_cs  <= (win_wr_c | win_rd_c) & ~win_video_c;
            bus.fp_video_cs <= (win_wr_c | win_rd_c) & win_video_c;
            bus.fp_wr       <= win_wr_c;
            bus.fp_rd       <= win_rd_c;
`ifdef FPRO_ARB_LOCK_EN
            op_lock         <= bus.m_lock[win_c];
`endif
          end
        end
        BUS: begin
          state           <= ACK;
          bus.fp_mmio_cs  <= 1'b0;
          bus.fp_video_cs <= 1'b0;
          bus.fp_wr       <= 1'b0;
          bus.fp_rd       <= 1'b0;
          bus.m_ack       <= bus.grant_id ? 2'b10 : 2'b01;
          if (bus.fp_rd) begin
            bus.m_rd_data <= bus.fp_rd_data;
          end
        end
        ACK: begin
          state     <= IDLE;
          bus.m_ack <= 2'b00;
          bus.busy  <= 1'b0;
`ifdef FPRO_ARB_LOCK_EN
          // A locked completion keeps priority where it is; an unlocked one releases it.
          if (op_lock) begin
            lock_valid <= 1'b1;
            lock_owner <= bus.grant_id;
          end else begin
            lock_valid <= 1'b0;
            rr         <= ~bus.grant_id;
          end
`else
          rr        <= ~bus.grant_id;
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// tb_fpro_bus_arbiter: scoreboard bench for fpro_bus_arbiter; build with +define+FPRO_ARB_LOCK_EN
// to include the bus-lock scenario.
module tb_fpro_bus_arbiter;
  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [1:0]        ack;
    logic [DATA_W-1:0] rd;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] slave_rd = '0;
  logic [DATA_W-1:0] model_rd = '0;
  logic [3:0]        strobes;
  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                hold_cnt = 0;
  bit                mon_en = 1'b0;

  always #5 clk = ~clk;

  fpro_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fpro_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // FPro slave: read data is combinational and always present.
  assign bus.fp_rd_data = slave_rd;
  assign strobes = {bus.fp_mmio_cs, bus.fp_video_cs, bus.fp_wr, bus.fp_rd};

  // Advance one cycle, sample after the falling edge, retire acks against the scoreboard
  // and drop the acknowledged request unless it is being held for back-to-back reissue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    #1;
    if (mon_en && bus.m_ack !== 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack got ack=%b expected none", bus.m_ack);
      end else begin
        e = sb.pop_front();
        if (bus.m_ack !== e.ack || bus.m_rd_data !== e.rd) begin
          errors++;
          $display("FAIL sb_ack got ack=%b rd=%h expected ack=%b rd=%h",
                   bus.m_ack, bus.m_rd_data, e.ack, e.rd);
        end
      end
      if (hold_cnt > 0) hold_cnt--;
      else bus.m_req = bus.m_req & ~bus.m_ack;
    end
  endtask

  task automatic set_req(input int m, input logic wr, input logic rd, input logic video,
                         input logic lock, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] data);
    bus.m_wr[m]    = wr;
    bus.m_rd[m]    = rd;
    bus.m_video[m] = video;
    bus.m_lock[m]  = lock;
    if (m == 0) begin
      bus.m0_addr    = addr;
      bus.m0_wr_data = data;
    end else begin
      bus.m1_addr    = addr;
      bus.m1_wr_data = data;
    end
    bus.m_req[m] = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy === 1'b0 && bus.m_req === 2'b00 && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout got busy=%b req=%b pending=%0d expected idle", bus.busy,
             bus.m_req, sb.size());
    sb.delete();
    bus.m_req = 2'b00;
  endtask

  task automatic test_reset();
    bus.m_req = 2'b00; bus.m_wr = 2'b00; bus.m_rd = 2'b00;
    bus.m_video = 2'b00; bus.m_lock = 2'b00;
    bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wr_data = '0; bus.m1_wr_data = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (strobes !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got %b expected 0000", strobes);
    end
    checks++;
    if ({bus.m_ack, bus.busy, bus.grant_id} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got ack=%b busy=%b grant=%b expected 0", bus.m_ack, bus.busy,
               bus.grant_id);
    end
    checks++;
    if (bus.fp_addr !== '0 || bus.fp_wr_data !== '0 || bus.m_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h rd=%h expected 0", bus.fp_addr,
               bus.fp_wr_data, bus.m_rd_data);
    end
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 21'h00010, 32'hDEADBEEF);
    sb.push_back('{2'b01, model_rd});
    tick();
    checks++;
    if (strobes !== 4'b1010 || bus.fp_addr !== 21'h00010 || bus.fp_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_strobe got strb=%b addr=%h wd=%h expected 1010 00010 deadbeef",
               strobes, bus.fp_addr, bus.fp_wr_data);
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.grant_id !== 1'b0) begin
      errors++;
      $display("FAIL write_grant got busy=%b grant=%b expected 1 0", bus.busy, bus.grant_id);
    end
    tick();
    checks++;
    if (strobes !== 4'b0000 || bus.fp_addr !== 21'h00010) begin
      errors++;
      $display("FAIL write_single got strb=%b addr=%h expected 0000 00010", strobes, bus.fp_addr);
    end
    wait_idle();
  endtask

  task automatic test_read();
    slave_rd = 32'h12345678;
    model_rd = 32'h12345678;
    set_req(1, 1'b0, 1'b1, 1'b1, 1'b0, 21'h100005, 32'h0);
    sb.push_back('{2'b10, model_rd});
    tick();
    checks++;
    if (strobes !== 4'b0101 || bus.fp_addr !== 21'h100005 || bus.grant_id !== 1'b1) begin
      errors++;
      $display("FAIL read_strobe got strb=%b addr=%h grant=%b expected 0101 100005 1",
               strobes, bus.fp_addr, bus.grant_id);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    // Both request together after rr returned to 0: 0,1,0,1 with acks three cycles apart.
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 21'h00020, 32'h0000AAAA);
    set_req(1, 1'b1, 1'b0, 1'b1, 1'b0, 21'h00030, 32'h0000BBBB);
    hold_cnt = 2;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{2'b01, model_rd});
      sb.push_back('{2'b10, model_rd});
    end
    tick();
    checks++;
    if (bus.grant_id !== 1'b0 || bus.fp_addr !== 21'h00020) begin
      errors++;
      $display("FAIL b2b_first got grant=%b addr=%h expected 0 00020", bus.grant_id, bus.fp_addr);
    end
    tick();
    checks++;
    if (bus.m_ack !== 2'b01) begin
      errors++; $display("FAIL b2b_ack0 got %b expected 01", bus.m_ack);
    end
    tick();
    tick();
    checks++;
    if (strobes !== 4'b0110 || bus.grant_id !== 1'b1 || bus.fp_addr !== 21'h00030) begin
      errors++;
      $display("FAIL b2b_second got strb=%b grant=%b addr=%h expected 0110 1 00030", strobes,
               bus.grant_id, bus.fp_addr);
    end
    tick();
    checks++;
    if (bus.m_ack !== 2'b10) begin
      errors++; $display("FAIL b2b_ack1 got %b expected 10", bus.m_ack);
    end
    wait_idle();
  endtask

  task automatic test_op_decode();
    slave_rd = 32'hA5A5A5A5;
    set_req(0, 1'b1, 1'b1, 1'b0, 1'b0, 21'h00044, 32'h11112222);
    sb.push_back('{2'b01, model_rd});
    tick();
    checks++;
    if (strobes !== 4'b1010) begin
      errors++; $display("FAIL wr_rd_both got strb=%b expected 1010", strobes);
    end
    wait_idle();
    set_req(0, 1'b0, 1'b0, 1'b1, 1'b0, 21'h00055, 32'h33334444);
    sb.push_back('{2'b01, model_rd});
    tick();
    checks++;
    if (strobes !== 4'b0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL noop_strobe got strb=%b busy=%b expected 0000 1", strobes, bus.busy);
    end
    tick();
    checks++;
    if (bus.m_ack !== 2'b01) begin
      errors++; $display("FAIL noop_ack got %b expected 01", bus.m_ack);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 21'h0001F, 32'h55555555);
    tick();
    reset_n = 1'b0;
    tick();
    checks++;
    if (strobes !== 4'b0000 || {bus.m_ack, bus.busy, bus.grant_id} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_ctrl got strb=%b ack=%b busy=%b grant=%b expected 0", strobes,
               bus.m_ack, bus.busy, bus.grant_id);
    end
    checks++;
    if (bus.fp_addr !== '0 || bus.fp_wr_data !== '0 || bus.m_rd_data !== '0) begin
      errors++;
      $display("FAIL midreset_data got addr=%h wd=%h rd=%h expected 0", bus.fp_addr,
               bus.fp_wr_data, bus.m_rd_data);
    end
    model_rd  = '0;
    reset_n   = 1'b1;
    bus.m_req = 2'b00;
    repeat (3) tick();
    checks++;
    if (bus.m_ack !== 2'b00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_noack got ack=%b busy=%b expected 00 0", bus.m_ack, bus.busy);
    end
    slave_rd = 32'hCAFEF00D;
    model_rd = 32'hCAFEF00D;
    set_req(0, 1'b0, 1'b1, 1'b0, 1'b0, 21'h00022, 32'h0);
    sb.push_back('{2'b01, model_rd});
    tick();
    checks++;
    if (strobes !== 4'b1001 || bus.fp_addr !== 21'h00022) begin
      errors++;
      $display("FAIL midreset_fresh got strb=%b addr=%h expected 1001 00022", strobes, bus.fp_addr);
    end
    wait_idle();
  endtask

`ifdef FPRO_ARB_LOCK_EN
  task automatic test_lock();
    int n;
    set_req(1, 1'b1, 1'b0, 1'b0, 1'b1, 21'h00040, 32'h00000001);
    sb.push_back('{2'b10, model_rd});
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 1'b0, 21'h00050, 32'h000000F0);
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (bus.m_req[1] !== 1'b0 && n < 20) begin
        tick();
        n++;
      end
      set_req(1, 1'b1, 1'b0, 1'b0, (k < 3) ? 1'b1 : 1'b0, 21'h00040, 32'(k + 1));
      sb.push_back('{2'b10, model_rd});
    end
    sb.push_back('{2'b01, model_rd});
    wait_idle();
    checks++;
    if (bus.grant_id !== 1'b0 || bus.fp_addr !== 21'h00050) begin
      errors++;
      $display("FAIL lock_release got grant=%b addr=%h expected 0 00050", bus.grant_id,
               bus.fp_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_op_decode();
    test_reset_mid();
`ifdef FPRO_ARB_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
